// File: rtl/sram_access_ctrl_pkg.sv
// Shared types and constants for the SLC-3 external SRAM access sequencer.
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } sram_state_t;

  localparam logic [3:0] SRAM_ADDR_PAD = 4'b0000;

  // Wide enough to hold max(a, b) - 1 without wrap.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_access_ctrl.sv
// Multi-cycle SRAM access sequencer: one read or write at a time, registered
// active-low strobes with programmable wait states and a one-cycle response.
module sram_access_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned RD_CYC = 2,
  parameter int unsigned WR_CYC = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        mem_ce,
  output logic        mem_ub,
  output logic        mem_lb,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [15:0] data_to_sram,
  input  logic [15:0] data_from_sram,
  output logic        data_drive
);

  localparam int unsigned CW = cnt_width(RD_CYC, WR_CYC);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYC - 1);

  sram_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          ce_q, ce_d;
  logic          ub_q, ub_d;
  logic          lb_q, lb_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic          drive_q, drive_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    ce_d        = ce_q;
    ub_d        = ub_q;
    lb_d        = lb_q;
    oe_d        = oe_q;
    we_d        = we_q;
    drive_d     = drive_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          ce_d   = 1'b0;
          ub_d   = 1'b0;
          lb_d   = 1'b0;
          we_d   = 1'b1;
          if (req_we) begin
            state_d = ST_WR_SETUP;
            wdata_d = req_wdata;
            oe_d    = 1'b1;
            drive_d = 1'b1;
          end else begin
            state_d = ST_RD;
            oe_d    = 1'b0;
            drive_d = 1'b0;
            cnt_d   = RD_LOAD;
          end
        end
      end

      ST_RD: begin
        if (cnt_q == '0) begin
          state_d     = ST_IDLE;
          rdata_d     = data_from_sram;
          rsp_valid_d = 1'b1;
          ce_d        = 1'b1;
          ub_d        = 1'b1;
          lb_d        = 1'b1;
          oe_d        = 1'b1;
          we_d        = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        we_d    = 1'b0;
        cnt_d   = WR_LOAD;
      end

      ST_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
          we_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_WR_HOLD: begin
        state_d     = ST_IDLE;
        drive_d     = 1'b0;
        rsp_valid_d = 1'b1;
        ce_d        = 1'b1;
        ub_d        = 1'b1;
        lb_d        = 1'b1;
        oe_d        = 1'b1;
        we_d        = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ce_q        <= 1'b1;
      ub_q        <= 1'b1;
      lb_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ce_q        <= ce_d;
      ub_q        <= ub_d;
      lb_q        <= lb_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      drive_q     <= drive_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign mem_ce       = ce_q;
  assign mem_ub       = ub_q;
  assign mem_lb       = lb_q;
  assign mem_oe       = oe_q;
  assign mem_we       = we_q;
  assign mem_addr     = {SRAM_ADDR_PAD, addr_q};
  assign data_to_sram = wdata_q;
  assign data_drive   = drive_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench: a 2/2 wait-state instance and a 1/1 instance share stimulus.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        sel;

  logic        ready_a, rsp_a, ce_a, ub_a, lb_a, oe_a, we_a, drive_a;
  logic [15:0] rdata_a, dts_a, dfs_a;
  logic [19:0] addr_a;
  logic        ready_b, rsp_b, ce_b, ub_b, lb_b, oe_b, we_b, drive_b;
  logic [15:0] rdata_b, dts_b, dfs_b;
  logic [19:0] addr_b;

  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
    int          acc;
    int          lat;
  } sb_t;
  sb_t         sb[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] last_rd;
  int          cyc = 0;
  int          vec = 0;
  int          miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_access_ctrl #(.RD_CYC(2), .WR_CYC(2)) dut_a (
    .Clk(clk), .Reset(rst_n), .req_valid(req_valid), .req_ready(ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_a), .rsp_rdata(rdata_a), .mem_ce(ce_a), .mem_ub(ub_a),
    .mem_lb(lb_a), .mem_oe(oe_a), .mem_we(we_a), .mem_addr(addr_a),
    .data_to_sram(dts_a), .data_from_sram(dfs_a), .data_drive(drive_a));

  sram_access_ctrl #(.RD_CYC(1), .WR_CYC(1)) dut_b (
    .Clk(clk), .Reset(rst_n), .req_valid(req_valid), .req_ready(ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_b), .rsp_rdata(rdata_b), .mem_ce(ce_b), .mem_ub(ub_b),
    .mem_lb(lb_b), .mem_oe(oe_b), .mem_we(we_b), .mem_addr(addr_b),
    .data_to_sram(dts_b), .data_from_sram(dfs_b), .data_drive(drive_b));

  // SRAM models: read data only while CE and OE are both low.
  assign dfs_a = (!ce_a && !oe_a) ? mem_a[addr_a[15:0]] : 16'hDEAD;
  assign dfs_b = (!ce_b && !oe_b) ? mem_b[addr_b[15:0]] : 16'hDEAD;
  always @(posedge clk) begin
    if (!ce_a && !we_a && drive_a) mem_a[addr_a[15:0]] <= dts_a;
    if (!ce_b && !we_b && drive_b) mem_b[addr_b[15:0]] <= dts_b;
  end

  wire        ready_o = sel ? ready_b : ready_a;
  wire        rsp_o   = sel ? rsp_b   : rsp_a;
  wire [15:0] rdata_o = sel ? rdata_b : rdata_a;
  wire        ce_o    = sel ? ce_b    : ce_a;
  wire        ub_o    = sel ? ub_b    : ub_a;
  wire        lb_o    = sel ? lb_b    : lb_a;
  wire        oe_o    = sel ? oe_b    : oe_a;
  wire        we_o    = sel ? we_b    : we_a;
  wire        drive_o = sel ? drive_b : drive_a;
  wire [19:0] addr_o  = sel ? addr_b  : addr_a;
  wire [15:0] dts_o   = sel ? dts_b   : dts_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("a_oe_we_overlap", {31'd0, !oe_a && !we_a}, 0);
      chk("a_drive_while_oe", {31'd0, drive_a && !oe_a}, 0);
      chk("b_oe_we_overlap", {31'd0, !oe_b && !we_b}, 0);
      chk("b_drive_while_oe", {31'd0, drive_b && !oe_b}, 0);
      if (rsp_o === 1'b1) begin
        if (sb.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          sb_t e;
          e = sb.pop_front();
          chk("latency", cyc - e.acc - 1, e.lat);
          chk(e.is_rd ? "rd_rdata" : "wr_keeps_rdata", {16'd0, rdata_o}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic push_req(input logic we, input logic [15:0] a, input logic [15:0] d);
    sb_t e;
    e.is_rd = !we;
    e.acc   = cyc;
    e.lat   = we ? (sel ? 3 : 4) : (sel ? 1 : 2);
    if (we) begin
      ref_mem[a] = d;
      e.data = last_rd;
    end else begin
      e.data  = ref_mem[a];
      last_rd = ref_mem[a];
    end
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("ready_timeout", 0, 1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    push_req(we, a, d);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ready_o !== 1'b1) && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic measure_low(input int which, output int n);
    n = 0;
    while (((which == 0) ? oe_o : we_o) === 1'b0 && n < 20) begin
      if (which == 0) chk("ce_low_with_oe", {31'd0, ce_o}, 0);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    sb.delete();
    last_rd = 16'h0000;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sel = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0;
    mem_a[16'h0012] = 16'hBEEF;
    mem_b[16'h0012] = 16'hBEEF;
    ref_mem[16'h0012] = 16'hBEEF;
    @(negedge clk);
    do_reset(3);
    chk("rst_strobes", {27'd0, ce_o, ub_o, lb_o, oe_o, we_o}, 32'h1F);
    chk("rst_drive", {31'd0, drive_o}, 0);
    chk("rst_addr", {12'd0, addr_o}, 0);
    chk("rst_dts", {16'd0, dts_o}, 0);
    chk("rst_rsp", {15'd0, rsp_o, rdata_o}, 0);
    chk("rst_ready", {31'd0, ready_o}, 1);

    // Reset aborting a write in WR_PULSE
    issue(1'b1, 16'h0100, 16'h7777);
    n = 0;
    while (we_o !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    chk("reach_wr_pulse", {31'd0, we_o}, 0);
    rst_n = 1'b0;
    sb.delete();
    ref_mem.delete(16'h0100);
    last_rd = 16'h0000;
    @(negedge clk);
    chk("abort_strobes", {27'd0, ce_o, ub_o, lb_o, oe_o, we_o}, 32'h1F);
    chk("abort_drive", {31'd0, drive_o}, 0);
    chk("abort_rsp", {31'd0, rsp_o}, 0);
    chk("abort_ready", {31'd0, ready_o}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read 0x0012
    issue(1'b0, 16'h0012, 16'h0000);
    chk("rd_addr", {12'd0, addr_o}, 32'h00012);
    chk("rd_ublb", {30'd0, ub_o, lb_o}, 0);
    measure_low(0, n);
    chk("rd_oe_cycles", n, 2);
    drain();

    // Write 0x1234 to 0xFFFF
    issue(1'b1, 16'hFFFF, 16'h1234);
    chk("wr_setup_we_drive", {30'd0, we_o, drive_o}, 32'h3);
    chk("wr_setup_ce_oe", {30'd0, ce_o, oe_o}, 32'h1);
    chk("wr_addr", {12'd0, addr_o}, 32'h0FFFF);
    chk("wr_dts", {16'd0, dts_o}, 32'h1234);
    @(negedge clk);
    measure_low(1, n);
    chk("wr_we_cycles", n, 2);
    chk("wr_hold_we_drive", {30'd0, we_o, drive_o}, 32'h3);
    chk("wr_hold_addr", {12'd0, addr_o}, 32'h0FFFF);
    @(negedge clk);
    chk("wr_done_drive_ce", {30'd0, drive_o, ce_o}, 32'h1);
    drain();
    chk("wr_mem_content", {16'd0, mem_a[16'hFFFF]}, 32'h1234);

    // Back-to-back write then read with req_valid held high
    issue(1'b1, 16'h0003, 16'hA5A5);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0003;
    n = 0;
    do begin @(negedge clk); n++; end while (ready_o !== 1'b1 && n < 20);
    chk("b2b_accept_in_rsp_cycle", {31'd0, rsp_o}, 1);
    push_req(1'b0, 16'h0003, 16'h0000);
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // Request while busy is ignored
    issue(1'b0, 16'h0012, 16'h0000);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0044;
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("busy_addr_held", {12'd0, addr_o}, 32'h00012);
    chk("busy_no_access", {31'd0, oe_o}, 1);

    // 1/1 wait-state instance
    sel = 1'b1;
    do_reset(2);
    @(negedge clk);
    issue(1'b1, 16'h0007, 16'h5A5A);
    @(negedge clk);
    measure_low(1, n);
    chk("b_wr_we_cycles", n, 1);
    drain();
    issue(1'b0, 16'h0007, 16'h0000);
    measure_low(0, n);
    chk("b_rd_oe_cycles", n, 1);
    drain();
    chk("b_rd_rdata_final", {16'd0, rdata_o}, 32'h5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
